// File: rtl/multi_cycle_adder.sv
// Sequential adder: operands are latched once, then summed CHUNK bits per clock
// with a running carry, and the result is held until the consumer takes it.
module multi_cycle_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cy_q;
   logic [CNT_W-1:0] cnt;
   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK-1:0] chunk_sum;
   logic             chunk_cy;
   logic [WIDTH-1:0] sum_upd;
   logic             last_chunk;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)   state_nxt = BUSY;
         BUSY:    if (last_chunk) state_nxt = DONE;
         DONE:    if (out_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Chunk select, chunk add and merge of the new chunk into the sum
   always_comb begin
      last_chunk = (cnt == LAST);
      chunk_a    = '0;
      chunk_b    = '0;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (cnt == CNT_W'(i)) begin
            chunk_a = a_q[i*CHUNK +: CHUNK];
            chunk_b = b_q[i*CHUNK +: CHUNK];
         end
      end
      {chunk_cy, chunk_sum} = (CHUNK+1)'(chunk_a) + (CHUNK+1)'(chunk_b) + (CHUNK+1)'(cy_q);
      sum_upd = sum;
      for (int unsigned i = 0; i < NCHUNK; i++) begin
         if (cnt == CNT_W'(i)) begin
            sum_upd[i*CHUNK +: CHUNK] = chunk_sum;
         end
      end
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         cy_q      <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q       <= a;
                  b_q       <= b;
                  cy_q      <= carry_in;
                  cnt       <= '0;
                  sum       <= '0;
                  carry_out <= 1'b0;
               end
            end
            BUSY: begin
               sum  <= sum_upd;
               cy_q <= chunk_cy;
               cnt  <= cnt + CNT_W'(1);
               if (last_chunk) carry_out <= chunk_cy;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: three instances (CHUNK 2, 8, 1) checked every cycle
// against a transaction-level timeline model, plus directed literal expectations.
module tb_multi_cycle_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       carry_in = 1'b0;
   logic       in_valid_v  [3];
   logic       out_ready_v [3];
   logic       in_ready_v  [3];
   logic       out_valid_v [3];
   logic       carry_out_v [3];
   logic [7:0] sum_v       [3];

   int checks   = 0;
   int failures = 0;
   int nch [3] = '{4, 1, 8};

   // Model state: pending transaction, edges since accept, expected {carry,sum}
   bit         m_pend [3];
   int         m_age  [3];
   logic [8:0] m_exp  [3];

   always #5 clk = ~clk;

   multi_cycle_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .sum(sum_v[0]), .carry_out(carry_out_v[0]));

   multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .sum(sum_v[1]), .carry_out(carry_out_v[1]));

   multi_cycle_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .sum(sum_v[2]), .carry_out(carry_out_v[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: result is due nch edges after accept, then waits for out_ready
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_pend[d] = 1'b0;
         end else if (!m_pend[d]) begin
            if (in_valid_v[d]) begin
               m_pend[d] = 1'b1;
               m_age[d]  = 0;
               m_exp[d]  = 9'(a) + 9'(b) + 9'(carry_in);
            end
         end else if (m_age[d] < nch[d]) begin
            m_age[d]++;
         end else if (out_ready_v[d]) begin
            m_pend[d] = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic exp_ov;
         exp_ov = m_pend[d] && (m_age[d] == nch[d]);
         chk($sformatf("in_ready[%0d]", d), 32'(in_ready_v[d]), 32'(!m_pend[d]));
         chk($sformatf("out_valid[%0d]", d), 32'(out_valid_v[d]), 32'(exp_ov));
         if (exp_ov)
            chk($sformatf("model_result[%0d]", d), 32'({carry_out_v[d], sum_v[d]}), 32'(m_exp[d]));
      end
   end

   // One transaction on instance d; out_ready held low for `hold` cycles once done
   task automatic txn(input int d, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input int hold, input logic [8:0] exp,
                      input int lat_exp, input string tag);
      int lat;
      @(negedge clk);
      a = ta; b = tb; carry_in = tc;
      in_valid_v[d]  = 1'b1;
      out_ready_v[d] = (hold == 0);
      @(negedge clk);
      in_valid_v[d] = 1'b0;
      lat = 0;
      while (!out_valid_v[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, " result"}, 32'({carry_out_v[d], sum_v[d]}), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " stall result"}, 32'({carry_out_v[d], sum_v[d]}), 32'(exp));
         chk({tag, " stall out_valid"}, 32'(out_valid_v[d]), 32'd1);
         chk({tag, " stall in_ready"}, 32'(in_ready_v[d]), 32'd0);
      end
      out_ready_v[d] = 1'b1;
      @(negedge clk);
      out_ready_v[d] = 1'b0;
   endtask

   initial begin
      logic [7:0] ta [4] = '{8'h10, 8'hF0, 8'h55, 8'h80};
      logic [7:0] tb [4] = '{8'h20, 8'h20, 8'hAA, 8'h80};
      logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int         acc [$];
      int         cyc, j, lat, seen;
      logic [7:0] ra, rb;
      logic       rc;

      for (int d = 0; d < 3; d++) begin
         in_valid_v[d]  = 1'b0;
         out_ready_v[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk("reset in_ready", 32'(in_ready_v[0]), 32'd1);
      chk("reset out_valid", 32'(out_valid_v[0]), 32'd0);
      chk("reset sum", 32'(sum_v[0]), 32'd0);
      chk("reset carry_out", 32'(carry_out_v[0]), 32'd0);
      rst = 1'b0;

      // Carry ripples through every chunk
      txn(0, 8'h01, 8'hFF, 1'b0, 0, 9'h100, 4, "ripple");
      // Long backpressure
      txn(0, 8'hFF, 8'hFF, 1'b1, 10, 9'h1FF, 4, "stall");
      txn(0, 8'h3C, 8'h0F, 1'b0, 1, 9'h04B, 4, "plain");

      // Reset on the second BUSY cycle abandons the result
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; carry_in = 1'b0;
      in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort in_ready", 32'(in_ready_v[0]), 32'd1);
      chk("abort out_valid", 32'(out_valid_v[0]), 32'd0);
      chk("abort sum", 32'(sum_v[0]), 32'd0);
      chk("abort carry_out", 32'(carry_out_v[0]), 32'd0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid_v[0]) seen++;
      end
      chk("abort no result", 32'(seen), 32'd0);
      out_ready_v[0] = 1'b0;

      // Back-to-back with out_ready high: one accept every NCHUNK+2 cycles
      @(negedge clk);
      out_ready_v[0] = 1'b1;
      in_valid_v[0]  = 1'b1;
      cyc = 0; j = 0;
      while (j < 4 && cyc < 80) begin
         if (in_ready_v[0]) begin
            a = ta[j]; b = tb[j]; carry_in = tc[j];
            acc.push_back(cyc);
            j++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid_v[0] = 1'b0;
      repeat (8) @(negedge clk);
      out_ready_v[0] = 1'b0;
      chk("b2b accepts", 32'(j), 32'd4);
      for (int k = 1; k < acc.size(); k++)
         chk($sformatf("b2b interval %0d", k), 32'(acc[k] - acc[k-1]), 32'd6);

      // Operands and handshakes churn while busy; result uses latched values
      @(negedge clk);
      a = 8'h12; b = 8'h34; carry_in = 1'b1;
      in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!out_valid_v[0] && lat < 40) begin
         a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
         in_valid_v[0]  = 1'($urandom);
         out_ready_v[0] = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("churn latency", 32'(lat), 32'd4);
      chk("churn result", 32'({carry_out_v[0], sum_v[0]}), 32'h047);
      in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
      @(negedge clk);
      out_ready_v[0] = 1'b0;
      repeat (2) @(negedge clk);

      // Full-width and single-bit chunk instances
      txn(1, 8'hFF, 8'h01, 1'b0, 0, 9'h100, 1, "c8 wrap");
      txn(2, 8'hFF, 8'h01, 1'b0, 0, 9'h100, 8, "c1 wrap");
      txn(2, 8'hA5, 8'h5A, 1'b1, 2, 9'h100, 8, "c1 cin");
      for (int d = 1; d < 3; d++) begin
         for (int n = 0; n < 100; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            txn(d, ra, rb, rc, int'($urandom_range(0, 2)), 9'(ra) + 9'(rb) + 9'(rc),
                nch[d], $sformatf("rand d%0d n%0d", d, n));
         end
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
